// File: rtl/gpio_controller.sv
// Memory-mapped GPIO: synchronised and debounced inputs, set/clear output aliases,
// sticky rising-edge flags (W1C) and a maskable level interrupt. Optional OUT_TOG under GPIO_TOGGLE_EN.
module gpio_controller #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned IN_WIDTH        = 4,
  parameter int unsigned OUT_WIDTH       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_select,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [IN_WIDTH-1:0]   io_in,
  output logic [OUT_WIDTH-1:0]  io_out,
  output logic                  irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [ADDR_WIDTH-1:0] A_IN      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_OUT     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_SET = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_CLR = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_EDGE    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_EN  = ADDR_WIDTH'(5);
`ifdef GPIO_TOGGLE_EN
  localparam logic [ADDR_WIDTH-1:0] A_OUT_TOG = ADDR_WIDTH'(6);
`endif

  logic [IN_WIDTH-1:0]             sync1_q, sync1_d;
  logic [IN_WIDTH-1:0]             sync2_q, sync2_d;
  logic [IN_WIDTH-1:0]             deb_q, deb_d;
  logic [IN_WIDTH-1:0]             deb_dly_q, deb_dly_d;
  logic [IN_WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]             edge_q, edge_d;
  logic [IN_WIDTH-1:0]             irq_en_q, irq_en_d;
  logic [OUT_WIDTH-1:0]            out_q, out_d;
  logic [DATA_WIDTH-1:0]           data_out_q, data_out_d;

  logic                  wr_en;
  logic                  rd_en;
  logic [OUT_WIDTH-1:0]  wdata_out;
  logic [IN_WIDTH-1:0]   wdata_in;
  logic [IN_WIDTH-1:0]   edge_clr;
  logic [IN_WIDTH-1:0]   rise;
  logic                  unused_data;

  assign wr_en       = chip_select & we;
  assign rd_en       = chip_select & ~we;
  assign wdata_out   = data_in[OUT_WIDTH-1:0];
  assign wdata_in    = data_in[IN_WIDTH-1:0];
  assign unused_data = ^data_in;

  // Two-flop synchroniser for the asynchronous pins
  always_comb begin
    sync1_d = io_in;
    sync2_d = sync1_q;
  end

  // Per-bit debounce: a bit follows the synced value only after it differs for DEBOUNCE_CYCLES cycles
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising edge of the debounced value, flagged one cycle after it settles
  always_comb begin
    deb_dly_d = deb_q;
    rise      = deb_q & ~deb_dly_q;
  end

  // Register writes; a new edge overrides a coincident W1C on the same bit
  always_comb begin
    out_d    = out_q;
    irq_en_d = irq_en_q;
    edge_clr = '0;
    if (wr_en) begin
      case (address)
        A_OUT:     out_d    = wdata_out;
        A_OUT_SET: out_d    = out_q | wdata_out;
        A_OUT_CLR: out_d    = out_q & ~wdata_out;
        A_EDGE:    edge_clr = wdata_in;
        A_IRQ_EN:  irq_en_d = wdata_in;
`ifdef GPIO_TOGGLE_EN
        A_OUT_TOG: out_d    = out_q ^ wdata_out;
`endif
        default:   ;
      endcase
    end
    edge_d = (edge_q & ~edge_clr) | rise;
  end

  // Registered read mux; idle and write cycles return zero
  always_comb begin
    data_out_d = '0;
    if (rd_en) begin
      case (address)
        A_IN:     data_out_d = DATA_WIDTH'(deb_q);
        A_OUT:    data_out_d = DATA_WIDTH'(out_q);
        A_EDGE:   data_out_d = DATA_WIDTH'(edge_q);
        A_IRQ_EN: data_out_d = DATA_WIDTH'(irq_en_q);
        default:  data_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      cnt_q      <= '0;
      edge_q     <= '0;
      irq_en_q   <= '0;
      out_q      <= '0;
      data_out_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      irq_en_q   <= irq_en_d;
      out_q      <= out_d;
      data_out_q <= data_out_d;
    end
  end

  assign io_out   = out_q;
  assign data_out = data_out_q;
  assign irq      = |(edge_q & irq_en_q);

endmodule

// File: tb/tb_gpio_controller.sv
// Randomised and directed bench for gpio_controller against a cycle-level behavioural model.
module tb_gpio_controller;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 4;
  localparam int OW = 4;
  localparam int DC = 4;
  localparam int unsigned OMASK = (1 << OW) - 1;
  localparam int unsigned IMASK = (1 << IW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          chip_select;
  logic          we;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [IW-1:0] io_in;
  logic [OW-1:0] io_out;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  gpio_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock(clock), .reset(reset), .chip_select(chip_select), .we(we), .address(address),
    .data_in(data_in), .data_out(data_out), .io_in(io_in), .io_out(io_out), .irq(irq)
  );

  always #5 clock = ~clock;

  // Reference state: pin history, settled input value with its stable-run length, register file
  int unsigned m_out, m_edge, m_en, m_dout;
  int unsigned m_hist1, m_hist2, m_deb, m_deb_prev;
  int          m_run [IW];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned mread(input int unsigned a);
    case (a)
      0: return m_deb;
      1: return m_out;
      4: return m_edge;
      5: return m_en;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = 0; m_edge = 0; m_en = 0; m_dout = 0;
    m_hist1 = 0; m_hist2 = 0; m_deb = 0; m_deb_prev = 0;
    for (int i = 0; i < IW; i++) m_run[i] = 0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus
  task automatic model_clock();
    int unsigned a, d, nout, nedge, nen, ndeb, rise;
    a = address;
    d = data_in;
    m_dout = (chip_select && !we) ? mread(a) : 0;
    nout = m_out; nedge = m_edge; nen = m_en;
    if (chip_select && we) begin
      case (a)
        1: nout = d & OMASK;
        2: nout = (m_out | d) & OMASK;
        3: nout = m_out & ~d & OMASK;
        4: nedge = m_edge & ~d;
        5: nen = d & IMASK;
`ifdef GPIO_TOGGLE_EN
        6: nout = (m_out ^ d) & OMASK;
`endif
        default: ;
      endcase
    end
    rise = m_deb & ~m_deb_prev;
    nedge = (nedge | rise) & IMASK;
    ndeb = m_deb;
    for (int i = 0; i < IW; i++) begin
      if (((m_hist2 >> i) & 1) != ((m_deb >> i) & 1)) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          ndeb = ndeb ^ (1 << i);
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_deb_prev = m_deb;
    m_deb = ndeb;
    m_hist2 = m_hist1;
    m_hist1 = io_in;
    m_out = nout; m_edge = nedge; m_en = nen;
  endtask

  task automatic step();
    @(posedge clock);
    model_clock();
    #1;
    chk("io_out", 32'(io_out), m_out);
    chk("data_out", data_out, m_dout);
    chk("irq", 32'(irq), 32'((m_edge & m_en) != 0));
  endtask

  task automatic set_bus(input logic c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chip_select = c; we = w; address = a; data_in = d;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_bus(1'b1, 1'b1, a, d);
    step();
    set_bus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    set_bus(1'b1, 1'b0, a, '0);
    step();
    set_bus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    io_in = '0;
    set_bus(1'b0, 1'b0, '0, '0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_io_out", 32'(io_out), 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_irq", 32'(irq), 0);
    reset = 1'b0;

    // Output register and set/clear aliases
    wr(5'h01, 32'hFFFF_FFFA); chk("out_wr", 32'(io_out), 32'hA);
    wr(5'h02, 32'h1);         chk("out_set", 32'(io_out), 32'hB);
    wr(5'h03, 32'h8);         chk("out_clr", 32'(io_out), 32'h3);
    rd(5'h01);                chk("out_rd", data_out, 32'h3);

    // Input latency: settled value first readable by a read issued on cycle 7
    io_in = 4'h1;
    for (int k = 1; k <= 7; k++) begin
      rd(5'h00);
      if (k == 6) chk("in_not_yet", data_out, 0);
      if (k == 7) chk("in_settled", data_out, 32'h1);
    end
    io_in = 4'h0;
    idle(10);
    wr(5'h04, 32'hF);
    rd(5'h04); chk("edge_cleared", data_out, 0);

    // Two-cycle glitch must be rejected
    io_in = 4'h1; idle(2);
    io_in = 4'h0; idle(10);
    rd(5'h00); chk("glitch_in", data_out, 0);
    rd(5'h04); chk("glitch_edge", data_out, 0);

    // Interrupt, W1C, and W1C colliding with a new edge
    wr(5'h05, 32'h1);
    io_in = 4'h1; idle(8);
    chk("irq_set", 32'(irq), 1);
    rd(5'h04); chk("edge_rd", data_out, 32'h1);
    wr(5'h04, 32'h1); chk("irq_clr", 32'(irq), 0);
    io_in = 4'h0; idle(10);
    io_in = 4'h1; idle(6);
    wr(5'h04, 32'h1); chk("w1c_vs_set", 32'(irq), 1);
    rd(5'h04); chk("w1c_vs_set_rd", data_out, 32'h1);

    // Unmapped/write-only reads and deselected writes
    rd(5'h1F); chk("rd_unmapped", data_out, 0);
    rd(5'h02); chk("rd_out_set", data_out, 0);
    set_bus(1'b0, 1'b1, 5'h01, 32'hF);
    step();
    set_bus(1'b0, 1'b0, '0, '0);
    chk("cs_low_out", 32'(io_out), 32'h3);
    chk("cs_low_dout", data_out, 0);

    // Optional toggle alias
    wr(5'h01, 32'h5);
    wr(5'h06, 32'hF);
`ifdef GPIO_TOGGLE_EN
    chk("toggle", 32'(io_out), 32'hA);
`else
    chk("toggle_off", 32'(io_out), 32'h5);
`endif
    rd(5'h06); chk("rd_tog", data_out, 0);

    // Asynchronous reset mid-run with outputs and flags active
    wr(5'h01, 32'hF);
    wr(5'h05, 32'h3);
    wr(5'h04, 32'hF);
    io_in = 4'h0; idle(10);
    wr(5'h04, 32'hF);
    io_in = 4'h3; idle(8);
    set_bus(1'b1, 1'b0, 5'h01, '0);
    step();
    chk("pre_rst_irq", 32'(irq), 1);
    chk("pre_rst_dout", data_out, 32'hF);
    #2 reset = 1'b1;
    #1;
    chk("arst_io_out", 32'(io_out), 0);
    chk("arst_data_out", data_out, 0);
    chk("arst_irq", 32'(irq), 0);
    set_bus(1'b0, 1'b0, '0, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    io_in = '0;
    model_reset();
    rd(5'h04); chk("arst_edge", data_out, 0);
    rd(5'h05); chk("arst_irq_en", data_out, 0);

    // Randomised traffic against the model
    for (int n = 0; n < 2000; n++) begin
      int unsigned sel;
      logic [AW-1:0] a;
      sel = $urandom_range(0, 9);
      a = (sel < 7) ? AW'(sel) : (sel == 7 ? 5'h1F : AW'($urandom));
      set_bus(1'($urandom_range(0, 3) != 0), 1'($urandom), a, DW'($urandom));
      if ($urandom_range(0, 5) == 0) io_in = io_in ^ IW'(1 << $urandom_range(0, IW - 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
